paddle_input_ctrl: RTL and testbench

- Upstream of the paddle controller.
- Takes raw, asynchronous, bouncing board push-buttons (right, left, fire).
- Produces clean, synchronized, debounced direction levels that feed the paddle's right/left inputs.
- Also produces a fire event latched per frame for the projectile logic, with left/right conflict resolution.

---
 rtl/gatorga_input_pkg.sv | 15 +
 rtl/btn_debounce.sv | 94 +++++++++
 rtl/paddle_input_ctrl.sv | 86 ++++++++
 tb/tb_paddle_input_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/gatorga_input_pkg.sv
// rtl/gatorga_input_pkg.sv - shared types and timing constants for the board button inputs
package gatorga_input_pkg;

    localparam int unsigned PIXEL_CLK_HZ            = 74_250_000;
    // 10 ms of stable input at the pixel clock
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = PIXEL_CLK_HZ / 100;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button: metastability synchronizer plus debounce FSM
module btn_debounce
    import gatorga_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic pixel_clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   btn_s;

    db_state_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   press_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // The counter only advances inside a wait state and is left before it could wrap.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state_q <= PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/paddle_input_ctrl.sv
// rtl/paddle_input_ctrl.sv - debounced paddle direction requests and per-frame fire latch
module paddle_input_ctrl
    import gatorga_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic pixel_clk,
    input  logic rst,
    input  logic fsync,
    input  logic btn_right_raw,
    input  logic btn_left_raw,
    input  logic btn_fire_raw,
    output logic right,
    output logic left,
    output logic fire_pulse,
    output logic fire_latched
);

    logic r_lvl, r_press;
    logic l_lvl, l_press;
    logic f_lvl, f_press;

    logic r_any, l_any;
    logic right_q, right_d;
    logic left_q, left_d;
    logic fire_latched_q, fire_latched_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_right (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .raw       (btn_right_raw),
        .level     (r_lvl),
        .press     (r_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_left (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .raw       (btn_left_raw),
        .level     (l_lvl),
        .press     (l_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_fire (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .raw       (btn_fire_raw),
        .level     (f_lvl),
        .press     (f_press)
    );

    // A press strobe always coincides with its level rising, so OR-ing it in changes nothing.
    assign r_any = r_lvl | r_press;
    assign l_any = l_lvl | l_press;

    always_comb begin
        right_d        = r_any & ~l_any;
        left_d         = l_any & ~r_any;
        fire_latched_d = fire_latched_q;
        // A press landing on the frame strobe belongs to the next frame, so set wins.
        if (fire_pulse) begin
            fire_latched_d = 1'b1;
        end else if (fsync) begin
            fire_latched_d = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            right_q        <= 1'b0;
            left_q         <= 1'b0;
            fire_latched_q <= 1'b0;
        end else begin
            right_q        <= right_d;
            left_q         <= left_d;
            fire_latched_q <= fire_latched_d;
        end
    end

    assign right        = right_q;
    assign left         = left_q;
    assign fire_pulse   = f_press & f_lvl;
    assign fire_latched = fire_latched_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb/tb_paddle_input_ctrl.sv - directed self-checking bench for paddle_input_ctrl
module tb_paddle_input_ctrl;

    logic pixel_clk = 1'b0;
    logic rst = 1'b1;
    logic fsync = 1'b0;
    logic btn_right_raw = 1'b0;
    logic btn_left_raw = 1'b0;
    logic btn_fire_raw = 1'b0;
    logic right, left, fire_pulse, fire_latched;

    int checks = 0;
    int failures = 0;

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .pixel_clk     (pixel_clk),
        .rst           (rst),
        .fsync         (fsync),
        .btn_right_raw (btn_right_raw),
        .btn_left_raw  (btn_left_raw),
        .btn_fire_raw  (btn_fire_raw),
        .right         (right),
        .left          (left),
        .fire_pulse    (fire_pulse),
        .fire_latched  (fire_latched)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge pixel_clk);
            #1;
        end
    endtask

    int pulses;
    int first_pulse;
    int max_left;

    initial begin
        // 1: reset state, right press and release latency
        tick(2);
        check("reset_right", right, 0);
        check("reset_left", left, 0);
        check("reset_fire_pulse", fire_pulse, 0);
        check("reset_fire_latched", fire_latched, 0);
        rst = 1'b0;
        tick(1);
        btn_right_raw = 1'b1;
        tick(7);
        check("t1_right_edge7", right, 0);
        tick(1);
        check("t1_right_edge8", right, 1);
        check("t1_left_idle", left, 0);
        tick(3);
        btn_right_raw = 1'b0;
        tick(7);
        check("t1_release_edge7", right, 1);
        tick(1);
        check("t1_release_edge8", right, 0);
        tick(4);

        // 2: glitchy left input is rejected
        max_left = 0;
        for (int i = 0; i < 24; i++) begin
            btn_left_raw = (i < 3) || (i >= 4 && i < 7);
            tick(1);
            if (left) max_left = 1;
        end
        check("t2_glitch_left", max_left, 0);
        btn_left_raw = 1'b0;

        // 3: left/right conflict resolution
        btn_right_raw = 1'b1;
        tick(8);
        check("t3_right_on", right, 1);
        btn_left_raw = 1'b1;
        tick(7);
        check("t3_right_before_conflict", right, 1);
        tick(1);
        check("t3_right_conflict", right, 0);
        check("t3_left_conflict", left, 0);
        tick(5);
        check("t3_both_held_right", right, 0);
        check("t3_both_held_left", left, 0);
        btn_right_raw = 1'b0;
        tick(7);
        check("t3_left_before_release", left, 0);
        tick(1);
        check("t3_left_after_release", left, 1);
        check("t3_right_after_release", right, 0);
        btn_left_raw = 1'b0;
        tick(10);
        check("t3_left_final", left, 0);

        // 4: one pulse per held press, fsync consumes the latch
        pulses = 0;
        first_pulse = 0;
        btn_fire_raw = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            fsync = (i == 30);
            tick(1);
            if (fire_pulse) begin
                pulses++;
                if (first_pulse == 0) first_pulse = i;
            end
            if (i == 8)  check("t4_latched_set", fire_latched, 1);
            if (i == 29) check("t4_latched_held", fire_latched, 1);
            if (i == 30) check("t4_latched_clear", fire_latched, 0);
        end
        fsync = 1'b0;
        check("t4_pulse_count", pulses, 1);
        check("t4_pulse_edge", first_pulse, 7);
        btn_fire_raw = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (fire_pulse) pulses++;
        end
        check("t4_release_no_pulse", pulses, 0);
        check("t4_latched_after_release", fire_latched, 0);

        // 5: press coinciding with fsync stays latched until the following fsync
        btn_fire_raw = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            fsync = (i == 8) || (i == 20);
            tick(1);
            if (i == 7)  check("t5_pulse", fire_pulse, 1);
            if (i == 8)  check("t5_latched_on_fsync", fire_latched, 1);
            if (i == 19) check("t5_latched_held", fire_latched, 1);
            if (i == 20) check("t5_latched_clear", fire_latched, 0);
        end
        fsync = 1'b0;
        btn_fire_raw = 1'b0;
        tick(10);

        // 6: reset mid-press discards debounce progress
        btn_right_raw = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("t6_rst_right", right, 0);
        check("t6_rst_left", left, 0);
        check("t6_rst_fire_pulse", fire_pulse, 0);
        check("t6_rst_fire_latched", fire_latched, 0);
        rst = 1'b0;
        tick(7);
        check("t6_right_edge7", right, 0);
        tick(1);
        check("t6_right_edge8", right, 1);
        btn_right_raw = 1'b0;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
